ysyx_24080018_imem_resp: RTL and testbench
==========================================

// Module: ysyx_24080018_imem_resp
// PURPOSE
//  Instruction-memory responder: the memory end of the instruction-fetch interface. Accepts one
//  fetch request at a time from the IFU, waits a configurable latency, then returns the 32-bit
//  word with a valid/ready handshake. Holds the program image in a word array that the bench or
//  loader fills through a load port. Sits between IFU and the program image, below top.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  byte address of word 0 (PC reset value)
//  DEPTH      1024           number of 32-bit words; power of two
//  LATENCY    1              extra wait cycles between accept and response, 0..15
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  req_valid  in   1   IFU presents a fetch address
//  req_ready  out  1   responder can accept a request this cycle
//  req_addr   in   32  byte address of the fetch
//  rsp_valid  out  1   response word valid
//  rsp_ready  in   1   IFU accepts the response
//  rsp_data   out  32  fetched instruction word
//  rsp_err    out  1   address misaligned or outside [BASE_ADDR, BASE_ADDR+4*DEPTH)
//  ld_en      in   1   write a word into the array
//  ld_addr    in   32  byte address for the load (same mapping as req_addr)
//  ld_data    in   32  word to write
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, req_ready=1 after release, rsp_valid=0, rsp_data=0,
//    rsp_err=0, counter=0. Array contents are not reset.
//  - FSM: IDLE -> (req_valid&&req_ready) -> WAIT if LATENCY>0, else RESP.
//    WAIT: counter loaded with LATENCY-1 on accept and decremented each cycle; -> RESP when 0.
//    RESP: rsp_valid=1; -> IDLE on rsp_valid&&rsp_ready.
//  - req_ready = (state==IDLE); single outstanding request; no accept in the cycle a response
//    completes.
//  - Latency: accept in cycle T -> rsp_valid first high in cycle T+1+LATENCY.
//  - The read is registered at accept: index = (req_addr-BASE_ADDR)>>2, taking bits
//    [log2(DEPTH)+1:2]. rsp_data and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
//  - Error: req_addr[1:0]!=0 or address out of range -> rsp_err=1, rsp_data=0. Same latency.
//    The array is not read.
//  - Load: ld_en writes ld_data in any state on the rising edge. An out-of-range or misaligned
//    ld_addr is ignored. A load to the same word in the accept cycle: the response returns the
//    OLD word; the new word is visible from the next accept.
//  - The address is 32-bit unsigned; the subtraction wraps, so an address below BASE_ADDR is
//    out of range.
//  - Reset mid-WAIT or mid-RESP aborts the transaction. No response is produced afterwards.
//  - req_valid while busy is ignored, and the IFU must hold it. No combinational path
//    req->rsp.
// STRUCTURE
//  - Shared package ysyx_24080018_pkg: RESET_PC (32'h8000_0000), state encoding
//    IMEM_IDLE/IMEM_WAIT/IMEM_RESP, INS_W=32.
//  - Sub-module ysyx_24080018_imem_array: DEPTH x 32 storage. One synchronous write port
//    (ld), one read port registered on enable (accept).
//  - FSM, latency counter, range/alignment check and response registers live in this module.
// TESTING
//  - Reset: hold rst=0 with req_valid=1 -> rsp_valid=0, req_ready=1 after release. Nothing
//    accepted during reset.
//  - Basic fetch, LATENCY=1: load 0x00000413 at 0x80000000, request 0x80000000 at T ->
//    rsp_valid at T+2, rsp_data=0x00000413, rsp_err=0.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0.
//    Completes on the first cycle rsp_ready=1.
//  - Errors: 0x80000002 -> rsp_err=1, data 0. 0x7FFFFFFC and 0x80001000 (DEPTH=1024) ->
//    rsp_err=1.
//  - LATENCY=0 and LATENCY=15: back-to-back fetches 0x80000000/4/8 with rsp_ready=1 ->
//    responses at T+1 / T+16, in order. Each next accept comes one cycle after the completion.
//  - Load/accept collision: ld_en to 0x80000004 in the accept cycle of a fetch to 0x80000004 ->
//    old word returned; a re-fetch returns the new word. Reset asserted in WAIT -> no rsp_valid.

Source files
------------

// File: rtl/ysyx_24080018_pkg.sv
// ============================================================================
//  Module      : ysyx_24080018_pkg
//  Description : Shared constants and state encoding for the instruction
//                memory responder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package ysyx_24080018_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int unsigned INS_W    = 32;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_24080018_imem_resp_if.sv
// ============================================================================
//  Module      : ysyx_24080018_imem_resp_if
//  Description : Fetch request/response handshake plus image load port.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface ysyx_24080018_imem_resp_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  // master: the IFU / loader side
  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // slave: the memory responder
  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_24080018_imem_array.sv
// ============================================================================
//  Module      : ysyx_24080018_imem_array
//  Description : DEPTH x 32 program storage, one synchronous write port and
//                one read port registered on enable.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ysyx_24080018_imem_array
  import ysyx_24080018_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             we,
  input  wire logic [IDX_W-1:0] waddr,
  input  wire logic [INS_W-1:0] wdata,
  input  wire logic             re,
  input  wire logic [IDX_W-1:0] raddr,
  output logic      [INS_W-1:0] rdata
);

  logic [INS_W-1:0] r_mem [DEPTH];
  logic [INS_W-1:0] r_rdata;

  // Contents are deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Same-edge write and read to one word returns the pre-write contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ysyx_24080018_imem_resp.sv
// ============================================================================
//  Module      : ysyx_24080018_imem_resp
//  Description : Instruction-memory responder: one outstanding fetch, fixed
//                latency, error on misaligned or out-of-range addresses.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ysyx_24080018_imem_resp
  import ysyx_24080018_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  ysyx_24080018_imem_resp_if.slave  bus
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam logic [3:0]  C_LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  imem_state_e      r_state;
  logic [3:0]       r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;

  logic [31:0]      w_req_off;
  logic             w_req_ok;
  logic [IDX_W-1:0] w_req_idx;
  logic [31:0]      w_ld_off;
  logic             w_ld_ok;
  logic [IDX_W-1:0] w_ld_idx;
  logic             w_accept;
  logic [INS_W-1:0] w_rd_data;

  // Unsigned wrap makes anything below BASE_ADDR land far out of range.
  assign w_req_off = bus.req_addr - BASE_ADDR;
  assign w_req_ok  = (bus.req_addr[1:0] == 2'b00) &&
                     ((w_req_off >> (IDX_W + 2)) == 32'd0);
  assign w_req_idx = w_req_off[IDX_W+1:2];

  assign w_ld_off  = bus.ld_addr - BASE_ADDR;
  assign w_ld_ok   = (bus.ld_addr[1:0] == 2'b00) &&
                     ((w_ld_off >> (IDX_W + 2)) == 32'd0);
  assign w_ld_idx  = w_ld_off[IDX_W+1:2];

  assign w_accept  = bus.req_valid && r_req_ready;

  ysyx_24080018_imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.ld_en && w_ld_ok),
    .waddr (w_ld_idx),
    .wdata (bus.ld_data),
    .re    (w_accept && w_req_ok),
    .raddr (w_req_idx),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IMEM_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IMEM_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_rsp_err   <= !w_req_ok;
            r_cnt       <= C_LAT_LOAD;
            if (LATENCY == 0) begin
              r_state     <= IMEM_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state     <= IMEM_WAIT;
            end
          end
        end
        IMEM_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= IMEM_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        IMEM_RESP: begin
          // req_ready rises only after completion, so no same-cycle re-accept.
          if (bus.rsp_ready) begin
            r_state     <= IMEM_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IMEM_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_err ? '0 : w_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24080018_imem_resp.sv
// ============================================================================
//  Module      : tb_ysyx_24080018_imem_resp
//  Description : Directed bench for the responder at LATENCY 0, 1 and 15.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_24080018_imem_resp;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int total;
  int bad;

  ysyx_24080018_imem_resp_if b0 ();
  ysyx_24080018_imem_resp_if b1 ();
  ysyx_24080018_imem_resp_if b15 ();

  assign b0.req_valid  = req_valid;  assign b0.req_addr  = req_addr;
  assign b0.rsp_ready  = rsp_ready;  assign b0.ld_en     = ld_en;
  assign b0.ld_addr    = ld_addr;    assign b0.ld_data   = ld_data;
  assign b1.req_valid  = req_valid;  assign b1.req_addr  = req_addr;
  assign b1.rsp_ready  = rsp_ready;  assign b1.ld_en     = ld_en;
  assign b1.ld_addr    = ld_addr;    assign b1.ld_data   = ld_data;
  assign b15.req_valid = req_valid;  assign b15.req_addr = req_addr;
  assign b15.rsp_ready = rsp_ready;  assign b15.ld_en    = ld_en;
  assign b15.ld_addr   = ld_addr;    assign b15.ld_data  = ld_data;

  ysyx_24080018_imem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  ysyx_24080018_imem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  ysyx_24080018_imem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(15))
    u_dut15 (.clk(clk), .rst(rst), .bus(b15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic f_rv(input int s);
    case (s)
      0:       return b0.rsp_valid;
      1:       return b1.rsp_valid;
      default: return b15.rsp_valid;
    endcase
  endfunction

  function automatic logic f_rr(input int s);
    case (s)
      0:       return b0.req_ready;
      1:       return b1.req_ready;
      default: return b15.req_ready;
    endcase
  endfunction

  function automatic logic [31:0] f_rd(input int s);
    case (s)
      0:       return b0.rsp_data;
      1:       return b1.rsp_data;
      default: return b15.rsp_data;
    endcase
  endfunction

  function automatic logic f_re(input int s);
    case (s)
      0:       return b0.rsp_err;
      1:       return b1.rsp_err;
      default: return b15.rsp_err;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Issue one fetch; k is the cycle offset of the first rsp_valid (1 = next cycle).
  task automatic fetch(input int s, input logic [31:0] a, input logic col,
                       input logic [31:0] cdata, output int k,
                       output logic [31:0] d, output logic e);
    req_valid = 1'b1;
    req_addr  = a;
    if (col) begin
      ld_en = 1'b1; ld_addr = a; ld_data = cdata;
    end
    @(negedge clk);
    req_valid = 1'b0;
    ld_en     = 1'b0;
    k = 1;
    while (!f_rv(s) && k < 40) begin
      @(negedge clk);
      k++;
    end
    d = f_rd(s);
    e = f_re(s);
  endtask

  task automatic b2b(input int s);
    logic [31:0] exp_w [3];
    int got;
    int k;
    exp_w[0] = 32'h0000_0413;
    exp_w[1] = 32'h1111_1111;
    exp_w[2] = 32'h2222_2222;
    got = 0;
    k   = 0;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    while (got < 3 && k < 200) begin
      @(negedge clk);
      k++;
      if (f_rv(s)) begin
        chk($sformatf("b2b%0d_time%0d", s, got), 32'(k), 32'(got * (s + 2) + s + 1));
        chk($sformatf("b2b%0d_data%0d", s, got), f_rd(s), exp_w[got]);
        got++;
        req_addr = 32'h8000_0000 + 32'(4 * got);
        if (got == 3) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk($sformatf("b2b%0d_count", s), 32'(got), 32'd3);
  endtask

  initial begin
    int          k;
    logic [31:0] d;
    logic        e;
    logic [31:0] held;
    logic        seen;

    total = 0; bad = 0;
    rst = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8000_0000; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // reset held with a pending request
    idle(3);
    chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(b1.req_ready), 32'd1);
    chk("rst_rsp_valid2", 32'(b1.rsp_valid), 32'd0);
    chk("rst_rsp_data", b1.rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(b1.rsp_err), 32'd0);

    load(32'h8000_0000, 32'h0000_0413);
    load(32'h8000_0004, 32'h1111_1111);
    load(32'h8000_0008, 32'h2222_2222);
    load(32'h8000_0FFC, 32'hDEAD_BEEF);

    // basic fetch, LATENCY=1
    fetch(1, 32'h8000_0000, 1'b0, '0, k, d, e);
    chk("basic_lat", 32'(k), 32'd2);
    chk("basic_data", d, 32'h0000_0413);
    chk("basic_err", 32'(e), 32'd0);
    idle(20);

    // backpressure
    rsp_ready = 1'b0;
    fetch(1, 32'h8000_0004, 1'b0, '0, k, d, e);
    chk("bp_lat", 32'(k), 32'd2);
    held = d;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(b1.rsp_valid), 32'd1);
      chk("bp_data", b1.rsp_data, 32'h1111_1111);
      chk("bp_hold", b1.rsp_data, held);
      chk("bp_req_ready", 32'(b1.req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", 32'(b1.rsp_valid), 32'd0);
    chk("bp_done_ready", 32'(b1.req_ready), 32'd1);
    idle(20);

    // error cases and the top boundary
    fetch(1, 32'h8000_0002, 1'b0, '0, k, d, e);
    chk("mis_lat", 32'(k), 32'd2);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_data", d, 32'd0);
    idle(20);
    fetch(1, 32'h7FFF_FFFC, 1'b0, '0, k, d, e);
    chk("below_err", 32'(e), 32'd1);
    chk("below_data", d, 32'd0);
    idle(20);
    fetch(1, 32'h8000_1000, 1'b0, '0, k, d, e);
    chk("above_err", 32'(e), 32'd1);
    idle(20);
    fetch(1, 32'h8000_0FFC, 1'b0, '0, k, d, e);
    chk("last_err", 32'(e), 32'd0);
    chk("last_data", d, 32'hDEAD_BEEF);
    idle(20);

    // back-to-back at both latency extremes
    b2b(0);
    idle(20);
    b2b(15);
    idle(20);

    // load/accept collision: old word first, new word on re-fetch
    fetch(1, 32'h8000_0004, 1'b1, 32'h5555_5555, k, d, e);
    chk("col_old", d, 32'h1111_1111);
    idle(20);
    fetch(1, 32'h8000_0004, 1'b0, '0, k, d, e);
    chk("col_new", d, 32'h5555_5555);
    idle(20);

    // ignored loads: misaligned and out of range alias word 1 if unchecked
    load(32'h8000_0006, 32'h9999_9999);
    load(32'h8000_1004, 32'h7777_7777);
    fetch(1, 32'h8000_0004, 1'b0, '0, k, d, e);
    chk("ld_ignore", d, 32'h5555_5555);
    idle(20);

    // reset during WAIT aborts the transaction
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    idle(3);
    chk("wait_busy", 32'(b15.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (b15.rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_ready", 32'(b15.req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
